// File: rtl/mm_trg_pkg.sv
// -----------------------------------------------------------------------------
// mm_trg_pkg
// Shared definitions for the minimum-trigger output arbiter:
//   - header / footer marker bytes and field offsets of the 128-bit framing beats
//   - EXEC_STATE encodings
//   - arbiter state enum
//   - footer beat builder
// -----------------------------------------------------------------------------
package mm_trg_pkg;

    localparam int FRAME_TDATA_W = 128;

    // Framing beat markers, both live in bits [127:120].
    localparam logic [7:0] HDR_MARKER = 8'hAA;
    localparam logic [7:0] FTR_MARKER = 8'h55;

    // Header beat field offsets (LSB positions).
    localparam int MARKER_LSB       = 120;
    localparam int HDR_ID_LSB       = 56;
    localparam int HDR_BASELINE_LSB = 44;
    localparam int HDR_TS_LSB       = 0;

    // Footer beat field offsets.
    localparam int FTR_TRUNC_BIT = 16;
    localparam int FTR_COUNT_LSB = 0;

    // EXEC_STATE encodings.
    localparam logic [1:0] EXEC_INIT = 2'b00;
    localparam logic [1:0] EXEC_TRG  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DROP    = 3'd3,
        ST_FOOTER  = 3'd4
    } arb_state_t;

    // Footer: marker, zero fill, truncation flag, forwarded payload beat count.
    function automatic logic [FRAME_TDATA_W-1:0] build_footer(
        input logic        trunc,
        input logic [15:0] beat_cnt
    );
        logic [FRAME_TDATA_W-1:0] beat;
        beat                        = '0;
        beat[MARKER_LSB +: 8]       = FTR_MARKER;
        beat[FTR_TRUNC_BIT]         = trunc;
        beat[FTR_COUNT_LSB +: 16]   = beat_cnt;
        return beat;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first asserted request at or
// after the pointer, wrapping past NUM_CH-1 back to 0.
//   i_req        in   NUM_CH          request vector
//   i_ptr        in   $clog2(NUM_CH)  highest-priority channel index
//   o_grant      out  NUM_CH          one-hot winner (0 if no request)
//   o_grant_idx  out  $clog2(NUM_CH)  binary index of the winner
//   o_valid      out  1               at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic              o_valid
);

    always_comb begin : p_pick
        int cand;
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(i_ptr) + i) % NUM_CH;
            if (!o_valid && i_req[IDX_W'(cand)]) begin
                o_valid                 = 1'b1;
                o_grant[IDX_W'(cand)]   = 1'b1;
                o_grant_idx             = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mm_trg_arbiter.sv
// -----------------------------------------------------------------------------
// mm_trg_arbiter
// Packet-level round-robin arbiter sharing one 128-bit AXI-Stream between
// NUM_CH trigger channels. Each granted frame is wrapped with a header beat
// (marker, channel id, baseline, time stamp) and a footer beat (marker,
// truncation flag, forwarded beat count). Frames longer than MAX_FRAME_BEATS
// are cut; the remainder is drained from the source and discarded.
//
// Ports:
//   AXIS_ACLK      in   1            clock
//   AXIS_ARESET    in   1            synchronous active-high reset
//   EXEC_STATE     in   2            2'b00 (INIT) blocks new grants
//   S_AXIS_TDATA   in   NUM_CH*128   per-channel payload
//   S_AXIS_TVALID  in   NUM_CH       per-channel valid
//   S_AXIS_TLAST   in   NUM_CH       per-channel end of frame
//   S_AXIS_TUSER   in   NUM_CH*56    {baseline, time_stamp}, used at grant
//   S_AXIS_TREADY  out  NUM_CH       per-channel ready
//   M_AXIS_TDATA   out  128          output data
//   M_AXIS_TVALID  out  1            output valid
//   M_AXIS_TLAST   out  1            footer beat marker
//   M_AXIS_TREADY  in   1            downstream ready
//   GRANT          out  NUM_CH       one-hot current owner, 0 when idle
//   FRAME_COUNT    out  32           frames emitted (wraps)
//   TRUNC_COUNT    out  16           truncated frames (saturates)
// -----------------------------------------------------------------------------
module mm_trg_arbiter
    import mm_trg_pkg::*;
#(
    parameter int NUM_CH               = 4,
    parameter int TIME_STAMP_WIDTH     = 44,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int TDATA_WIDTH          = 128,
    parameter int MAX_FRAME_BEATS      = 100
) (
    input  logic                                                   AXIS_ACLK,
    input  logic                                                   AXIS_ARESET,
    input  logic [1:0]                                             EXEC_STATE,
    input  logic [NUM_CH*TDATA_WIDTH-1:0]                          S_AXIS_TDATA,
    input  logic [NUM_CH-1:0]                                      S_AXIS_TVALID,
    input  logic [NUM_CH-1:0]                                      S_AXIS_TLAST,
    input  logic [NUM_CH*(ADC_RESOLUTION_WIDTH+TIME_STAMP_WIDTH)-1:0] S_AXIS_TUSER,
    output logic [NUM_CH-1:0]                                      S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]                                 M_AXIS_TDATA,
    output logic                                                   M_AXIS_TVALID,
    output logic                                                   M_AXIS_TLAST,
    input  logic                                                   M_AXIS_TREADY,
    output logic [NUM_CH-1:0]                                      GRANT,
    output logic [31:0]                                            FRAME_COUNT,
    output logic [15:0]                                            TRUNC_COUNT
);

    localparam int          USER_W    = ADC_RESOLUTION_WIDTH + TIME_STAMP_WIDTH;
    localparam int          IDX_W     = $clog2(NUM_CH);
    localparam logic [15:0] MAX_BEATS = 16'(MAX_FRAME_BEATS);

    // ---------------------------------------------------------------- state
    arb_state_t                     r_state;
    logic [IDX_W-1:0]               r_ptr;
    logic [NUM_CH-1:0]              r_grant;
    logic [IDX_W-1:0]               r_gidx;
    logic [ADC_RESOLUTION_WIDTH-1:0] r_baseline;
    logic [TIME_STAMP_WIDTH-1:0]    r_time_stamp;
    logic [15:0]                    r_beat_cnt;
    logic                           r_trunc;
    logic [TDATA_WIDTH-1:0]         r_m_tdata;
    logic                           r_m_tvalid;
    logic                           r_m_tlast;
    logic [31:0]                    r_frame_cnt;
    logic [15:0]                    r_trunc_cnt;

    // ---------------------------------------------------------------- wires
    logic [TDATA_WIDTH-1:0] w_ch_data [NUM_CH];
    logic [USER_W-1:0]      w_ch_user [NUM_CH];
    logic [NUM_CH-1:0]      w_next_grant;
    logic [IDX_W-1:0]       w_next_idx;
    logic                   w_any_req;
    logic                   w_run;
    logic                   w_load;
    logic                   w_src_valid;
    logic                   w_src_last;
    logic [TDATA_WIDTH-1:0] w_src_data;
    logic [15:0]            w_cnt_inc;
    logic [TDATA_WIDTH-1:0] w_header;
    logic [TDATA_WIDTH-1:0] w_footer;
    logic [NUM_CH-1:0]      w_s_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_ch_data[g] = S_AXIS_TDATA[g*TDATA_WIDTH +: TDATA_WIDTH];
        assign w_ch_user[g] = S_AXIS_TUSER[g*USER_W +: USER_W];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .i_req       (S_AXIS_TVALID),
        .i_ptr       (r_ptr),
        .o_grant     (w_next_grant),
        .o_grant_idx (w_next_idx),
        .o_valid     (w_any_req)
    );

    // Output register may take a new beat when empty or being drained now.
    assign w_load      = !r_m_tvalid || M_AXIS_TREADY;
    assign w_run       = (EXEC_STATE != EXEC_INIT);
    assign w_src_valid = |(S_AXIS_TVALID & r_grant);
    assign w_src_last  = |(S_AXIS_TLAST & r_grant);
    assign w_src_data  = w_ch_data[r_gidx];
    assign w_cnt_inc   = r_beat_cnt + 16'd1;
    assign w_footer    = build_footer(r_trunc, r_beat_cnt);

    always_comb begin
        w_header                                          = '0;
        w_header[MARKER_LSB +: 8]                         = HDR_MARKER;
        w_header[HDR_ID_LSB +: 8]                         = 8'(r_gidx);
        w_header[HDR_BASELINE_LSB +: ADC_RESOLUTION_WIDTH] = r_baseline;
        w_header[HDR_TS_LSB +: TIME_STAMP_WIDTH]          = r_time_stamp;
    end

    // Only the owner is ever ready. In PAYLOAD readiness follows the output
    // register so each accepted beat has a slot; in DROP beats are discarded
    // so the owner is drained at full rate. Held low during reset.
    always_comb begin
        w_s_ready = '0;
        if (!AXIS_ARESET) begin
            if (r_state == ST_PAYLOAD) begin
                w_s_ready = r_grant & {NUM_CH{w_load}};
            end else if (r_state == ST_DROP) begin
                w_s_ready = r_grant;
            end
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_baseline   <= '0;
            r_time_stamp <= '0;
            r_beat_cnt   <= '0;
            r_trunc      <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_frame_cnt  <= '0;
            r_trunc_cnt  <= '0;
        end else begin
            // Beat consumed (or slot empty): drop valid unless a state below
            // loads a new beat in this same cycle. TDATA is left untouched.
            if (w_load) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_run && w_any_req) begin
                        r_grant      <= w_next_grant;
                        r_gidx       <= w_next_idx;
                        r_baseline   <= w_ch_user[w_next_idx][USER_W-1 -: ADC_RESOLUTION_WIDTH];
                        r_time_stamp <= w_ch_user[w_next_idx][TIME_STAMP_WIDTH-1:0];
                        r_state      <= ST_HEADER;
                    end
                end

                ST_HEADER: begin
                    if (w_load) begin
                        r_m_tdata  <= w_header;
                        r_m_tvalid <= 1'b1;
                        r_state    <= ST_PAYLOAD;
                    end
                end

                ST_PAYLOAD: begin
                    if (w_load && w_src_valid) begin
                        r_m_tdata  <= w_src_data;
                        r_m_tvalid <= 1'b1;
                        r_beat_cnt <= w_cnt_inc;
                        // TLAST on the limit beat wins: frame ends untruncated.
                        if (w_src_last) begin
                            r_state <= ST_FOOTER;
                        end else if (w_cnt_inc == MAX_BEATS) begin
                            r_trunc <= 1'b1;
                            r_state <= ST_DROP;
                        end
                    end
                end

                ST_DROP: begin
                    if (w_src_valid && w_src_last) begin
                        r_state <= ST_FOOTER;
                    end
                end

                ST_FOOTER: begin
                    if (w_load) begin
                        r_m_tdata   <= w_footer;
                        r_m_tvalid  <= 1'b1;
                        r_m_tlast   <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                        if (r_trunc && (r_trunc_cnt != 16'hFFFF)) begin
                            r_trunc_cnt <= r_trunc_cnt + 16'd1;
                        end
                        r_ptr      <= (r_gidx == IDX_W'(NUM_CH - 1)) ? '0 : r_gidx + 1'b1;
                        r_grant    <= '0;
                        r_beat_cnt <= '0;
                        r_trunc    <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign S_AXIS_TREADY = w_s_ready;
    assign M_AXIS_TDATA  = r_m_tdata;
    assign M_AXIS_TVALID = r_m_tvalid;
    assign M_AXIS_TLAST  = r_m_tlast;
    assign GRANT         = r_grant;
    assign FRAME_COUNT   = r_frame_cnt;
    assign TRUNC_COUNT   = r_trunc_cnt;

endmodule

// File: tb/tb_mm_trg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mm_trg_arbiter
// Directed bench for mm_trg_arbiter (NUM_CH=4, MAX_FRAME_BEATS=4). Source
// frames are queued per channel, the output stream is logged and compared
// against frames built by the bench from header/payload/footer formulas.
// -----------------------------------------------------------------------------
module tb_mm_trg_arbiter;

    localparam int NCH  = 4;
    localparam int MAXB = 4;
    localparam int DW   = 128;
    localparam int UW   = 56;

    logic              clk;
    logic              AXIS_ARESET;
    logic [1:0]        EXEC_STATE;
    logic [NCH*DW-1:0] S_AXIS_TDATA;
    logic [NCH-1:0]    S_AXIS_TVALID;
    logic [NCH-1:0]    S_AXIS_TLAST;
    logic [NCH*UW-1:0] S_AXIS_TUSER;
    logic [NCH-1:0]    S_AXIS_TREADY;
    logic [DW-1:0]     M_AXIS_TDATA;
    logic              M_AXIS_TVALID;
    logic              M_AXIS_TLAST;
    logic              M_AXIS_TREADY;
    logic [NCH-1:0]    GRANT;
    logic [31:0]       FRAME_COUNT;
    logic [15:0]       TRUNC_COUNT;

    mm_trg_arbiter #(
        .NUM_CH               (NCH),
        .TIME_STAMP_WIDTH     (44),
        .ADC_RESOLUTION_WIDTH (12),
        .TDATA_WIDTH          (DW),
        .MAX_FRAME_BEATS      (MAXB)
    ) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (AXIS_ARESET),
        .EXEC_STATE    (EXEC_STATE),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .GRANT         (GRANT),
        .FRAME_COUNT   (FRAME_COUNT),
        .TRUNC_COUNT   (TRUNC_COUNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-channel source storage: {tlast, tdata}.
    logic [DW:0]   src_mem [NCH][64];
    int            src_rd  [NCH];
    int            src_wr  [NCH];
    logic [UW-1:0] usr     [NCH];

    logic [DW:0] out_log[$];
    logic [DW:0] exp_log[$];

    logic bp_en  = 1'b0;
    logic gap_en = 1'b0;

    // Snapshot of handshake signals taken just before each active edge.
    logic [NCH-1:0] p_svalid = '0;
    logic [NCH-1:0] p_sready = '0;
    logic           p_mvalid = 1'b0;
    logic           p_mready = 1'b0;
    logic           p_mlast  = 1'b0;
    logic [DW-1:0]  p_mdata  = '0;

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW:0] hdr(input int c, input logic [UW-1:0] u);
        return {1'b0, 8'hAA, 56'h0, 8'(c), u};
    endfunction

    function automatic logic [DW:0] pay(input int c, input int f, input int b);
        return {1'b0, 8'(c), 8'(f), 8'(b), 104'h1234_5678_9ABC_DEF0_1122_3344_55};
    endfunction

    function automatic logic [DW:0] ftr(input logic t, input int cnt);
        return {1'b1, 8'h55, 103'h0, t, 16'(cnt)};
    endfunction

    task automatic add_frame(input int c, input int f, input int n);
        logic [DW:0] beat;
        for (int b = 0; b < n; b++) begin
            beat                     = pay(c, f, b);
            beat[DW]                 = (b == n - 1);
            src_mem[c][src_wr[c]]    = beat;
            src_wr[c]++;
        end
    endtask

    task automatic exp_frame(input int c, input int f, input int n);
        int k;
        k = (n < MAXB) ? n : MAXB;
        exp_log.push_back(hdr(c, usr[c]));
        for (int b = 0; b < k; b++) exp_log.push_back(pay(c, f, b));
        exp_log.push_back(ftr(n > MAXB, k));
    endtask

    // One clock: account for the handshakes of the edge just passed, check
    // output stability under backpressure, then drive the next cycle.
    task automatic tick();
        @(negedge clk);
        if (!AXIS_ARESET) begin
            for (int c = 0; c < NCH; c++) begin
                if (p_svalid[c] && p_sready[c]) src_rd[c]++;
            end
            if (p_mvalid && p_mready) out_log.push_back({p_mlast, p_mdata});
            if (p_mvalid && !p_mready) begin
                check("hold_valid", (DW+1)'(M_AXIS_TVALID), (DW+1)'(1));
                check("hold_beat", {M_AXIS_TLAST, M_AXIS_TDATA}, {p_mlast, p_mdata});
            end
        end
        M_AXIS_TREADY = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        for (int c = 0; c < NCH; c++) begin
            logic first;
            logic hold;
            logic gap;
            hold = p_svalid[c] && !p_sready[c];
            if (src_rd[c] < src_wr[c]) begin
                first = (src_rd[c] == 0) || src_mem[c][src_rd[c]-1][DW];
                gap   = gap_en && !first && !hold && ($urandom_range(0, 2) == 0);
                S_AXIS_TVALID[c]          = !gap;
                S_AXIS_TLAST[c]           = src_mem[c][src_rd[c]][DW];
                S_AXIS_TDATA[c*DW +: DW]  = src_mem[c][src_rd[c]][DW-1:0];
            end else begin
                S_AXIS_TVALID[c]          = 1'b0;
                S_AXIS_TLAST[c]           = 1'b0;
                S_AXIS_TDATA[c*DW +: DW]  = '0;
            end
        end
        #1;
        p_svalid = S_AXIS_TVALID;
        p_sready = S_AXIS_TREADY;
        p_mvalid = M_AXIS_TVALID;
        p_mready = M_AXIS_TREADY;
        p_mlast  = M_AXIS_TLAST;
        p_mdata  = M_AXIS_TDATA;
    endtask

    task automatic wait_out(input int n);
        int cyc;
        cyc = 0;
        while (out_log.size() < n && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    task automatic compare_log(input string tag);
        repeat (4) tick();
        check({tag, "_len"}, (DW+1)'(out_log.size()), (DW+1)'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++) begin
            if (i < out_log.size()) check($sformatf("%s_beat%0d", tag, i), out_log[i], exp_log[i]);
        end
        out_log.delete();
        exp_log.delete();
    endtask

    task automatic flush_sources();
        for (int c = 0; c < NCH; c++) begin
            src_rd[c] = 0;
            src_wr[c] = 0;
        end
    endtask

    task automatic do_reset();
        AXIS_ARESET = 1'b1;
        flush_sources();
        tick();
        tick();
    endtask

    initial begin
        int n_before;
        usr[0] = {12'hA00, 44'h000_0000_0100};
        usr[1] = {12'h010, 44'h000_0000_0123};
        usr[2] = {12'hFFF, 44'hFFF_FFFF_FFFF};
        usr[3] = {12'h3C3, 44'h500_0000_000A};
        S_AXIS_TUSER  = {usr[3], usr[2], usr[1], usr[0]};
        S_AXIS_TDATA  = '0;
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        M_AXIS_TREADY = 1'b1;
        EXEC_STATE    = 2'b11;

        // Reset state.
        do_reset();
        check("rst_tvalid", (DW+1)'(M_AXIS_TVALID), '0);
        check("rst_tlast",  (DW+1)'(M_AXIS_TLAST),  '0);
        check("rst_tdata",  (DW+1)'(M_AXIS_TDATA),  '0);
        check("rst_sready", (DW+1)'(S_AXIS_TREADY), '0);
        check("rst_grant",  (DW+1)'(GRANT),         '0);
        check("rst_frames", (DW+1)'(FRAME_COUNT),   '0);
        check("rst_truncs", (DW+1)'(TRUNC_COUNT),   '0);
        AXIS_ARESET = 1'b0;
        tick();

        // Single channel, 3-beat frame; grant appears one cycle after request.
        add_frame(1, 1, 3);
        exp_frame(1, 1, 3);
        tick();
        check("s1_grant_lat0", (DW+1)'(GRANT), '0);
        tick();
        check("s1_grant", (DW+1)'(GRANT), (DW+1)'(4'b0010));
        wait_out(5);
        compare_log("s1");
        check("s1_frames", (DW+1)'(FRAME_COUNT), (DW+1)'(1));
        check("s1_truncs", (DW+1)'(TRUNC_COUNT), '0);
        check("s1_grant_idle", (DW+1)'(GRANT), '0);

        // Round robin from pointer 0: channels 0, 2, 3 together, channel 0
        // has a second frame queued and must wait for 2 and 3.
        do_reset();
        AXIS_ARESET = 1'b0;
        tick();
        add_frame(0, 2, 2);
        add_frame(0, 3, 1);
        add_frame(2, 2, 1);
        add_frame(3, 2, 3);
        exp_frame(0, 2, 2);
        exp_frame(2, 2, 1);
        exp_frame(3, 2, 3);
        exp_frame(0, 3, 1);
        wait_out(15);
        compare_log("s2");
        check("s2_frames", (DW+1)'(FRAME_COUNT), (DW+1)'(4));

        // 7-beat frame against a 4-beat limit: 4 forwarded, 3 drained.
        add_frame(1, 4, 7);
        exp_frame(1, 4, 7);
        wait_out(6);
        compare_log("s3");
        check("s3_drained", (DW+1)'(src_rd[1]), (DW+1)'(src_wr[1]));
        check("s3_frames", (DW+1)'(FRAME_COUNT), (DW+1)'(5));
        check("s3_truncs", (DW+1)'(TRUNC_COUNT), (DW+1)'(1));

        // TLAST exactly on the limit beat: no truncation.
        add_frame(2, 5, 4);
        exp_frame(2, 5, 4);
        wait_out(6);
        compare_log("s4");
        check("s4_frames", (DW+1)'(FRAME_COUNT), (DW+1)'(6));
        check("s4_truncs", (DW+1)'(TRUNC_COUNT), (DW+1)'(1));

        // Random downstream backpressure and source gaps; pointer is now 3.
        bp_en  = 1'b1;
        gap_en = 1'b1;
        add_frame(3, 6, 2);
        add_frame(0, 6, 5);
        exp_frame(3, 6, 2);
        exp_frame(0, 6, 5);
        wait_out(10);
        bp_en  = 1'b0;
        gap_en = 1'b0;
        compare_log("s5");
        check("s5_frames", (DW+1)'(FRAME_COUNT), (DW+1)'(8));
        check("s5_truncs", (DW+1)'(TRUNC_COUNT), (DW+1)'(2));

        // INIT blocks new grants; INIT mid-frame lets the frame finish.
        EXEC_STATE = 2'b00;
        add_frame(1, 7, 3);
        repeat (6) tick();
        check("s6_init_grant", (DW+1)'(GRANT), '0);
        check("s6_init_out", (DW+1)'(out_log.size()), '0);
        check("s6_init_tvalid", (DW+1)'(M_AXIS_TVALID), '0);
        EXEC_STATE = 2'b11;
        tick();
        check("s6_run_grant", (DW+1)'(GRANT), (DW+1)'(4'b0010));
        EXEC_STATE = 2'b00;
        exp_frame(1, 7, 3);
        wait_out(5);
        compare_log("s6");
        check("s6_frames", (DW+1)'(FRAME_COUNT), (DW+1)'(9));
        check("s6_grant_idle", (DW+1)'(GRANT), '0);

        // Reset in the middle of a payload: everything clears, no footer.
        EXEC_STATE = 2'b11;
        add_frame(2, 8, 6);
        wait_out(3);
        check("s7_progress", (DW+1)'(out_log.size() >= 3), (DW+1)'(1));
        n_before    = out_log.size();
        AXIS_ARESET = 1'b1;
        flush_sources();
        tick();
        check("s7_tvalid", (DW+1)'(M_AXIS_TVALID), '0);
        check("s7_tlast",  (DW+1)'(M_AXIS_TLAST),  '0);
        check("s7_tdata",  (DW+1)'(M_AXIS_TDATA),  '0);
        check("s7_sready", (DW+1)'(S_AXIS_TREADY), '0);
        check("s7_grant",  (DW+1)'(GRANT),         '0);
        check("s7_frames", (DW+1)'(FRAME_COUNT),   '0);
        check("s7_truncs", (DW+1)'(TRUNC_COUNT),   '0);
        AXIS_ARESET = 1'b0;
        repeat (5) tick();
        check("s7_no_footer", (DW+1)'(out_log.size()), (DW+1)'(n_before));
        check("s7_idle_tvalid", (DW+1)'(M_AXIS_TVALID), '0);
        check("s7_idle_grant", (DW+1)'(GRANT), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
